// File: rtl/mem_wb_pkg.sv
// Shared types and helpers for the MEM->WB skid-buffered pipeline stage.
package mem_wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;

  // Widest datapath wb_select handles; callers zero-extend into it and truncate back.
  localparam int unsigned SEL_W = 64;

  // Encoding mirrors {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } stage_state_e;

  function automatic logic [SEL_W-1:0] wb_select(input logic             mem_to_reg,
                                                 input logic [SEL_W-1:0] alu,
                                                 input logic [SEL_W-1:0] rd_data);
    return mem_to_reg ? rd_data : alu;
  endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// One payload register with valid flag; clear only drops valid, data is kept.
module mem_wb_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage register with 2-entry skid buffer, flush, x0 write gating,
// a WB forwarding tap and a saturating stall-cycle counter.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned REG_AW        = REG_AW_DEF,
  parameter int unsigned ZERO_REG_GATE = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_write_en,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [REG_AW-1:0] in_rd_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_write_en,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_read_data,
  output logic [REG_AW-1:0] out_rd_num,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PW = 3 + 2 * DATA_W + REG_AW;

  logic          main_valid, skid_valid;
  logic [PW-1:0] main_q, skid_q, main_d, in_pl;
  logic          main_load, main_clear, skid_load, skid_clear;
  logic          in_fire, out_fire, gated_reg_write;
  stage_state_e  state;

  assign gated_reg_write = in_reg_write && !((ZERO_REG_GATE != 0) && (in_rd_num == '0));
  assign in_pl = {in_mem_write_en, in_mem_to_reg, gated_reg_write,
                  in_alu_result, in_read_data, in_rd_num};

  // in_ready comes straight from the skid valid flop: no combinational path from out_ready.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  assign state     = stage_state_e'({skid_valid, main_valid});

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_pl;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: main_load = in_fire;
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
          end else if (out_fire) begin
            main_clear = 1'b1;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_load  = 1'b1;
            main_d     = skid_q;
            skid_clear = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  mem_wb_slot #(
    .W(PW)
  ) u_main_slot (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .clear(main_clear),
    .d    (main_d),
    .valid(main_valid),
    .q    (main_q)
  );

  mem_wb_slot #(
    .W(PW)
  ) u_skid_slot (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .clear(skid_clear),
    .d    (in_pl),
    .valid(skid_valid),
    .q    (skid_q)
  );

  assign {out_mem_write_en, out_mem_to_reg, out_reg_write,
          out_alu_result, out_read_data, out_rd_num} = main_q;

  assign fwd_valid = out_valid && out_reg_write;
  assign fwd_rd    = out_rd_num;
  assign fwd_data  = DATA_W'(wb_select(out_mem_to_reg, SEL_W'(out_alu_result),
                                       SEL_W'(out_read_data)));

  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

  a_no_skid_without_main : assert property (@(posedge clk) disable iff (rst)
    !(skid_valid && !main_valid));

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a FIFO reference model.
module tb_mem_wb_skid_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic          in_mem_write_en, in_mem_to_reg, in_reg_write;
  logic [DW-1:0] in_alu_result, in_read_data;
  logic [AW-1:0] in_rd_num;
  logic          out_valid, out_ready;
  logic          out_mem_write_en, out_mem_to_reg, out_reg_write;
  logic [DW-1:0] out_alu_result, out_read_data;
  logic [AW-1:0] out_rd_num;
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(
    .DATA_W       (DW),
    .REG_AW       (AW),
    .ZERO_REG_GATE(1),
    .CNT_W        (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_mem_write_en (in_mem_write_en),
    .in_mem_to_reg   (in_mem_to_reg),
    .in_reg_write    (in_reg_write),
    .in_alu_result   (in_alu_result),
    .in_read_data    (in_read_data),
    .in_rd_num       (in_rd_num),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_mem_write_en(out_mem_write_en),
    .out_mem_to_reg  (out_mem_to_reg),
    .out_reg_write   (out_reg_write),
    .out_alu_result  (out_alu_result),
    .out_read_data   (out_read_data),
    .out_rd_num      (out_rd_num),
    .fwd_valid       (fwd_valid),
    .fwd_rd          (fwd_rd),
    .fwd_data        (fwd_data),
    .stall_cnt       (stall_cnt)
  );

  typedef struct {
    logic          we;
    logic          m2r;
    logic          rw;
    logic [DW-1:0] alu;
    logic [DW-1:0] rdd;
    logic [AW-1:0] rd;
  } pl_t;

  pl_t         mq[$];
  int unsigned mcnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic m2r, input logic rw,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rdd,
                       input logic [AW-1:0] rd);
    in_valid        = v;
    in_mem_write_en = we;
    in_mem_to_reg   = m2r;
    in_reg_write    = rw;
    in_alu_result   = alu;
    in_read_data    = rdd;
    in_rd_num       = rd;
  endtask

  // Compare at the falling edge, then advance the model by the same clock edge.
  task automatic cycle();
    pl_t h, p;
    bit  rdy, ifire, ofire;
    @(negedge clk);
    check("out_valid", out_valid, mq.size() != 0);
    check("in_ready", in_ready, mq.size() < 2);
    check("stall_cnt", stall_cnt, mcnt);
    if (mq.size() != 0) begin
      h = mq[0];
      check("out_we", out_mem_write_en, h.we);
      check("out_m2r", out_mem_to_reg, h.m2r);
      check("out_rw", out_reg_write, h.rw);
      check("out_alu", out_alu_result, h.alu);
      check("out_rdd", out_read_data, h.rdd);
      check("out_rd", out_rd_num, h.rd);
      check("fwd_valid", fwd_valid, h.rw);
      check("fwd_rd", fwd_rd, h.rd);
      check("fwd_data", fwd_data, h.m2r ? h.rdd : h.alu);
    end else begin
      check("fwd_valid_idle", fwd_valid, 0);
    end
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      rdy   = mq.size() < 2;
      ifire = in_valid && rdy;
      ofire = (mq.size() != 0) && out_ready;
      if ((mq.size() != 0) && !out_ready && (mcnt < CNT_MAX)) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) begin
          p.we  = in_mem_write_en;
          p.m2r = in_mem_to_reg;
          p.rw  = in_reg_write && (in_rd_num != 0);
          p.alu = in_alu_result;
          p.rdd = in_read_data;
          p.rd  = in_rd_num;
          mq.push_back(p);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    mq.delete();
    mcnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      check("rst_fwd_rd", fwd_rd, 0);
      check("rst_fwd_data", fwd_data, 0);
      check("rst_out_alu", out_alu_result, 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    mq.delete();
    mcnt = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 32'h66, 5'd3);

    // Reset held with in_valid high
    do_reset(3);

    // Streaming
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 5'd1);
    cycle();
    check("stream_first", out_alu_result, 32'h10);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 5'd2);
    cycle();
    check("stream_second", out_alu_result, 32'h20);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 5'd3);
    cycle();
    check("stream_third", out_alu_result, 32'h30);
    in_valid = 1'b0;
    cycle();

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 32'h0, 5'd4);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 32'h0, 5'd5);
    cycle();
    in_valid = 1'b0;
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_a", out_alu_result, 32'hA);
    cycle();
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Flush while both slots are full
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h1, 32'h0, 5'd6);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h2, 32'h0, 5'd7);
    cycle();
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 32'h0, 5'd8);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycle();
    cycle();

    // x0 gate and forwarding
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 32'h0, 5'd0);
    cycle();
    check("x0_out_rw", out_reg_write, 0);
    check("x0_fwd_valid", fwd_valid, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hBEEF, 32'hDEAD, 5'd7);
    cycle();
    check("fwd_sel_data", fwd_data, 32'hDEAD);
    check("fwd_sel_rd", fwd_rd, 7);
    check("fwd_sel_valid", fwd_valid, 1);
    in_valid = 1'b0;
    cycle();

    // Random traffic with flushes and one mid-stream reset
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      if (i == 150) do_reset(2);
      cycle();
    end
    flush = 1'b0;

    // Counter saturation
    in_valid = 1'b0;
    do_reset(1);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h99, 32'h0, 5'd9);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("stall_saturated", stall_cnt, 15);
    check("stall_out_valid", out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
